// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and opcode helpers for the fetch sequencer
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    WAIT_BR = 2'd2,
    ERR     = 2'd3
  } fetch_state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic is_ctrl_flow(input logic [6:0] opcode);
    return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_ack_timer.sv
// rtl/fetch_ack_timer.sv - counts request cycles without ack; flags the last allowed one
module fetch_ack_timer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  logic [W-1:0] count;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  // expired marks the cycle whose edge would bring the count to ACK_TIMEOUT
  generate
    if (ACK_TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = enable && (count == W'(ACK_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer: PC owner, imem handshake, decode hand-off
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4,
  input  logic        dec_ready,
  input  logic        br_resolved,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        fetch_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  br_next;
  logic         timer_clr;
  logic         timer_en;
  logic         timer_expired;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc_plus4  = inst_pc + 32'd4;
  assign br_next   = br_taken ? br_target : pc + 32'd4;

  assign timer_en  = (state == FETCH) && !imem_ack && !flush;
  assign timer_clr = (state != FETCH) || imem_ack || flush;

  fetch_ack_timer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_timer (
    .CLK    (CLK),
    .RESET  (RESET),
    .clear  (timer_clr),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= FETCH;
      pc         <= RESET_VEC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      fetch_err  <= 1'b0;
    end else if (flush && (state != ERR)) begin
      // flush beats any ack or resolve arriving in the same cycle
      inst_valid <= 1'b0;
      if (flush_pc[1:0] != 2'b00) begin
        state     <= ERR;
        fetch_err <= 1'b1;
      end else begin
        pc    <= flush_pc;
        state <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            inst       <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end else if (timer_expired) begin
            state     <= ERR;
            fetch_err <= 1'b1;
          end
        end
        HOLD: begin
          if (dec_ready) begin
            inst_valid <= 1'b0;
            if (is_ctrl_flow(inst[6:0])) begin
              state <= WAIT_BR;
            end else begin
              pc    <= pc + 32'd4;
              state <= FETCH;
            end
          end
        end
        WAIT_BR: begin
          if (br_resolved) begin
            if (br_next[1:0] != 2'b00) begin
              state     <= ERR;
              fetch_err <= 1'b1;
            end else begin
              pc    <= br_next;
              state <= FETCH;
            end
          end
        end
        ERR: begin
          inst_valid <= 1'b0;
        end
        default: state <= ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC   = 32'h0000_0000;
  localparam int          ACK_TIMEOUT = 16;

  logic        CLK;
  logic        RESET;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        dec_ready;
  logic        br_resolved;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        fetch_err;

  int          n_checks;
  int          n_errors;
  logic [31:0] sb_pc_q[$];
  logic [31:0] sb_inst_q[$];

  fetch_ctrl #(
    .RESET_VEC  (RESET_VEC),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .pc_plus4   (pc_plus4),
    .dec_ready  (dec_ready),
    .br_resolved(br_resolved),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .fetch_err  (fetch_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] addr);
    return {addr[24:0], 7'b0010011};
  endfunction

  task automatic do_reset();
    imem_ack    = 1'b0;
    imem_data   = '0;
    dec_ready   = 1'b0;
    br_resolved = 1'b0;
    br_taken    = 1'b0;
    br_target   = '0;
    flush       = 1'b0;
    flush_pc    = '0;
    RESET       = 1'b1;
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, RESET_VEC);
    check("rst_valid", {31'b0, inst_valid}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    tick();
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
    RESET = 1'b0;
    sb_pc_q.delete();
    sb_inst_q.delete();
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (imem_req) ok = 1'b1;
      else tick();
    end
    if (!ok) check("req_wait", 32'd0, 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] addr, input logic [31:0] word);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    check("req_addr", imem_addr, addr);
    tick();
    check("req_held", {31'b0, imem_req}, 32'd1);
    imem_ack  = 1'b1;
    imem_data = word;
    sb_pc_q.push_back(addr);
    sb_inst_q.push_back(word);
    tick();
    imem_ack  = 1'b0;
    imem_data = '0;
    check("valid_after_ack", {31'b0, inst_valid}, 32'd1);
  endtask

  task automatic accept();
    logic [31:0] epc;
    logic [31:0] einst;
    if (sb_pc_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    epc   = sb_pc_q.pop_front();
    einst = sb_inst_q.pop_front();
    check("valid", {31'b0, inst_valid}, 32'd1);
    check("inst", inst, einst);
    check("inst_pc", inst_pc, epc);
    check("pc_plus4", pc_plus4, epc + 32'd4);
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    check("valid_drop", {31'b0, inst_valid}, 32'd0);
  endtask

  task automatic run_to_branch(input logic [31:0] br_word);
    do_reset();
    fetch_one(32'h0, word_for(32'h0));
    accept();
    fetch_one(32'h4, word_for(32'h4));
    accept();
    fetch_one(32'h8, br_word);
    accept();
    for (int i = 0; i < 3; i++) begin
      check("wait_br_req", {31'b0, imem_req}, 32'd0);
      tick();
    end
  endtask

  initial begin
    bit ok;
    n_checks = 0;
    n_errors = 0;
    RESET    = 1'b0;
    #2;

    // sequential fetch; a stray resolve outside WAIT_BR must not redirect
    do_reset();
    br_resolved = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h200;
    for (int i = 0; i < 4; i++) begin
      fetch_one(32'(i * 4), word_for(32'(i * 4)));
      accept();
    end
    br_resolved = 1'b0;
    wait_req(ok);
    check("seq_next_addr", imem_addr, 32'h10);

    // taken branch
    run_to_branch(32'h0000_0063);
    br_resolved = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h40;
    tick();
    br_resolved = 1'b0;
    check("taken_req", {31'b0, imem_req}, 32'd1);
    check("taken_addr", imem_addr, 32'h40);
    fetch_one(32'h40, word_for(32'h40));
    accept();

    // not-taken jump
    run_to_branch(32'h0000_006F);
    br_resolved = 1'b1;
    br_taken    = 1'b0;
    br_target   = 32'h40;
    tick();
    br_resolved = 1'b0;
    check("nt_addr", imem_addr, 32'hC);

    // misaligned target, then flush in ERR is ignored
    run_to_branch(32'h0000_0067);
    br_resolved = 1'b1;
    br_taken    = 1'b1;
    br_target   = 32'h42;
    tick();
    br_resolved = 1'b0;
    check("mis_err", {31'b0, fetch_err}, 32'd1);
    check("mis_req", {31'b0, imem_req}, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'h100;
    tick();
    flush = 1'b0;
    check("err_flush_req", {31'b0, imem_req}, 32'd0);
    check("err_flush_err", {31'b0, fetch_err}, 32'd1);
    check("err_flush_valid", {31'b0, inst_valid}, 32'd0);

    // decode stall
    do_reset();
    fetch_one(32'h0, 32'h1234_5013);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", {31'b0, inst_valid}, 32'd1);
      check("stall_inst", inst, 32'h1234_5013);
      check("stall_pc", inst_pc, 32'h0);
      check("stall_req", {31'b0, imem_req}, 32'd0);
      tick();
    end
    accept();

    // flush coinciding with ack, then minimum-latency ack
    do_reset();
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_0013;
    flush     = 1'b1;
    flush_pc  = 32'h100;
    tick();
    imem_ack = 1'b0;
    flush    = 1'b0;
    check("flush_valid", {31'b0, inst_valid}, 32'd0);
    check("flush_req", {31'b0, imem_req}, 32'd1);
    check("flush_addr", imem_addr, 32'h100);
    imem_ack  = 1'b1;
    imem_data = word_for(32'h100);
    sb_pc_q.push_back(32'h100);
    sb_inst_q.push_back(word_for(32'h100));
    tick();
    imem_ack = 1'b0;
    check("min_lat_valid", {31'b0, inst_valid}, 32'd1);
    accept();

    // PC wraps at the top of the address space
    flush    = 1'b1;
    flush_pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    fetch_one(32'hFFFF_FFFC, word_for(32'hFFFF_FFFC));
    accept();
    wait_req(ok);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_err", {31'b0, fetch_err}, 32'd0);

    // misaligned flush target
    do_reset();
    flush    = 1'b1;
    flush_pc = 32'h102;
    tick();
    flush = 1'b0;
    check("flush_mis_err", {31'b0, fetch_err}, 32'd1);
    check("flush_mis_req", {31'b0, imem_req}, 32'd0);

    // ack timeout
    do_reset();
    for (int i = 0; i < ACK_TIMEOUT - 1; i++) tick();
    check("to_early_err", {31'b0, fetch_err}, 32'd0);
    check("to_early_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("to_err", {31'b0, fetch_err}, 32'd1);
    check("to_req", {31'b0, imem_req}, 32'd0);
    check("to_valid", {31'b0, inst_valid}, 32'd0);
    do_reset();
    check("post_rst_err", {31'b0, fetch_err}, 32'd0);
    check("post_rst_addr", imem_addr, RESET_VEC);

    check("sb_drain", 32'(sb_pc_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
